// File: rtl/sha3_scan_pkg.sv
// Shared types for the SHA3 scan request/result protocol.
// Result record, dispatcher state encoding and datapath widths.
package sha3_scan_pkg;

    localparam int SCAN_WORD_W  = 64;
    localparam int SCAN_NONCE_W = 32;

    typedef struct packed {
        logic [SCAN_NONCE_W-1:0] nonce;
        logic [SCAN_WORD_W-1:0]  hash_msw;
    } scan_result_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
    } dispatch_state_e;

endpackage

// File: rtl/sha3_result_fifo.sv
// Synchronous result FIFO with sticky overflow; head visible combinationally, 1-cycle push-to-valid.
// No backpressure to the writer: a push while full without a pop is dropped and flagged.
module sha3_result_fifo
    import sha3_scan_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  scan_result_t i_dat,
    input  logic         i_pop,
    input  logic         i_clr_ovf,
    output logic         o_vld,
    output scan_result_t o_dat,
    output logic         o_overflow
);

    localparam int AW = $clog2(DEPTH);

    scan_result_t r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         r_overflow;
    logic         w_empty;
    logic         w_full;
    logic         w_do_pop;
    logic         w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !w_do_push) r_overflow <= 1'b1;
            else if (i_clr_ovf)       r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end

    assign o_vld      = !w_empty;
    assign o_dat      = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_overflow = r_overflow;

endmodule

// File: rtl/sha3_scan_dispatcher.sv
// Walks a nonce range, streaming one templated request per CHUNK; first req 1 cycle after start/chunk_done.
// Request words held stable until req_ready; results buffered in a drop-on-full FIFO.
module sha3_scan_dispatcher
    import sha3_scan_pkg::*;
#(
    parameter int BLOCK_WORDS = 24,
    parameter int NONCE_IDX   = 19,
    parameter int CHUNK       = 256,
    parameter int RES_DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tpl_wr,
    input  logic [4:0]  i_tpl_addr,
    input  logic [63:0] i_tpl_data,
    input  logic        i_start,
    input  logic [31:0] i_nonce_base,
    input  logic [31:0] i_nonce_count,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_job_done,
    output logic        o_req_valid,
    output logic [63:0] o_req_data,
    output logic        o_req_last,
    input  logic        i_req_ready,
    input  logic        i_chunk_done,
    input  logic        i_res_valid_in,
    input  logic [31:0] i_res_nonce_in,
    input  logic [63:0] i_res_hash_in,
    output logic        o_res_valid,
    output logic [31:0] o_res_nonce,
    output logic [63:0] o_res_hash,
    input  logic        i_res_pop,
    output logic        o_res_overflow
);

    localparam logic [4:0]  LAST_W  = 5'(BLOCK_WORDS - 1);
    localparam logic [4:0]  NIDX_W  = 5'(NONCE_IDX);
    localparam logic [31:0] CHUNK_N = 32'(CHUNK);

    logic [63:0]     r_tpl [BLOCK_WORDS];
    dispatch_state_e r_state;
    dispatch_state_e w_state_nxt;
    logic [31:0]     r_cur;
    logic [31:0]     r_rem;
    logic [31:0]     w_rem_dec;
    logic [4:0]      r_w;
    logic            r_abort_pend;
    logic            r_zero_done;
    logic            w_start_ok;
    logic            w_hs;
    logic            w_last;
    logic [63:0]     w_word;
    scan_result_t    w_res_in;
    scan_result_t    w_res_head;

    always_ff @(posedge i_clk) begin
        if (i_tpl_wr && (i_tpl_addr < 5'(BLOCK_WORDS))) r_tpl[i_tpl_addr] <= i_tpl_data;
    end

    assign w_start_ok = i_start && (r_state == IDLE);
    assign w_last     = (r_w == LAST_W);
    assign w_hs       = (r_state == SEND) && i_req_ready;
    assign w_rem_dec  = (r_rem <= CHUNK_N) ? '0 : r_rem - CHUNK_N;
    assign w_word     = (r_w == NIDX_W) ? {r_tpl[r_w][63:32], r_cur} : r_tpl[r_w];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_job_done  = r_zero_done;
        o_req_valid = 1'b0;
        o_req_data  = '0;
        o_req_last  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok && (i_nonce_count != '0)) w_state_nxt = SEND;
            end
            SEND: begin
                o_busy      = 1'b1;
                o_req_valid = 1'b1;
                o_req_data  = w_word;
                o_req_last  = w_last;
                if (w_hs && w_last) w_state_nxt = WAIT;
            end
            WAIT: begin
                o_busy = 1'b1;
                if (i_chunk_done) w_state_nxt = ((w_rem_dec == '0) || r_abort_pend) ? DONE : SEND;
            end
            DONE: begin
                o_job_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur        <= '0;
            r_rem        <= '0;
            r_w          <= '0;
            r_abort_pend <= 1'b0;
            r_zero_done  <= 1'b0;
        end else begin
            // An empty job still owes the host a completion pulse.
            r_zero_done <= w_start_ok && (i_nonce_count == '0);
            if (r_state == DONE)                    r_abort_pend <= 1'b0;
            else if (i_abort && (r_state != IDLE))  r_abort_pend <= 1'b1;
            case (r_state)
                IDLE: if (w_start_ok) begin
                    r_cur <= i_nonce_base;
                    r_rem <= i_nonce_count;
                    r_w   <= '0;
                end
                SEND: if (w_hs && !w_last) r_w <= r_w + 5'd1;
                WAIT: if (i_chunk_done) begin
                    r_cur <= r_cur + CHUNK_N;
                    r_rem <= w_rem_dec;
                    r_w   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign w_res_in.nonce    = i_res_nonce_in;
    assign w_res_in.hash_msw = i_res_hash_in;

    sha3_result_fifo #(
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (i_res_valid_in),
        .i_dat      (w_res_in),
        .i_pop      (i_res_pop),
        .i_clr_ovf  (w_start_ok),
        .o_vld      (o_res_valid),
        .o_dat      (w_res_head),
        .o_overflow (o_res_overflow)
    );

    assign o_res_nonce = w_res_head.nonce;
    assign o_res_hash  = w_res_head.hash_msw;

endmodule

// File: tb/tb_sha3_scan_dispatcher.sv
// Directed + randomized bench for sha3_scan_dispatcher against a job/queue-level reference model.
module tb_sha3_scan_dispatcher;

    localparam int BW   = 24;
    localparam int NIDX = 19;
    localparam int CH   = 256;
    localparam int RD   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tpl_wr;
    logic [4:0]  tpl_addr;
    logic [63:0] tpl_data;
    logic        start;
    logic [31:0] nonce_base;
    logic [31:0] nonce_count;
    logic        abort;
    logic        busy;
    logic        job_done;
    logic        req_valid;
    logic [63:0] req_data;
    logic        req_last;
    logic        req_ready;
    logic        chunk_done;
    logic        res_valid_in;
    logic [31:0] res_nonce_in;
    logic [63:0] res_hash_in;
    logic        res_valid;
    logic [31:0] res_nonce;
    logic [63:0] res_hash;
    logic        res_pop;
    logic        res_overflow;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] tpl_m [BW];
    logic [95:0] res_q [$];
    logic        ovf_m;

    always #5 clk = ~clk;

    sha3_scan_dispatcher dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_tpl_wr       (tpl_wr),
        .i_tpl_addr     (tpl_addr),
        .i_tpl_data     (tpl_data),
        .i_start        (start),
        .i_nonce_base   (nonce_base),
        .i_nonce_count  (nonce_count),
        .i_abort        (abort),
        .o_busy         (busy),
        .o_job_done     (job_done),
        .o_req_valid    (req_valid),
        .o_req_data     (req_data),
        .o_req_last     (req_last),
        .i_req_ready    (req_ready),
        .i_chunk_done   (chunk_done),
        .i_res_valid_in (res_valid_in),
        .i_res_nonce_in (res_nonce_in),
        .i_res_hash_in  (res_hash_in),
        .o_res_valid    (res_valid),
        .o_res_nonce    (res_nonce),
        .o_res_hash     (res_hash),
        .i_res_pop      (res_pop),
        .o_res_overflow (res_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      64'(busy),         64'd0);
        check({tag, "_job_done"},  64'(job_done),     64'd0);
        check({tag, "_req_valid"}, 64'(req_valid),    64'd0);
        check({tag, "_req_data"},  req_data,          64'd0);
        check({tag, "_req_last"},  64'(req_last),     64'd0);
        check({tag, "_res_valid"}, 64'(res_valid),    64'd0);
        check({tag, "_res_nonce"}, 64'(res_nonce),    64'd0);
        check({tag, "_res_hash"},  res_hash,          64'd0);
        check({tag, "_res_ovf"},   64'(res_overflow), 64'd0);
    endtask

    task automatic load_tpl(input bit directed);
        for (int i = 0; i < BW + 2; i++) begin
            @(negedge clk);
            tpl_wr = 1'b1;
            if (i < BW) begin
                tpl_addr = 5'(i);
                tpl_data = directed ? 64'h1111_0000_0000_0000 + 64'(i) : {$urandom, $urandom};
                tpl_m[i] = tpl_data;
            end else begin
                // Out-of-range addresses must not disturb the template.
                tpl_addr = (i == BW) ? 5'd24 : 5'd31;
                tpl_data = {$urandom, $urandom};
            end
        end
        @(negedge clk);
        tpl_wr = 1'b0;
    endtask

    // One scanner-side cycle on the result path, checked against the queue model.
    task automatic fifo_cycle(input bit push, input bit pop);
        logic [95:0] d;
        bit do_pop;
        bit do_push;
        check("res_overflow", 64'(res_overflow), 64'(ovf_m));
        check("res_valid", 64'(res_valid), 64'(res_q.size() != 0));
        if (res_q.size() != 0) begin
            check("res_nonce", 64'(res_nonce), 64'(res_q[0][95:64]));
            check("res_hash",  res_hash,       res_q[0][63:0]);
        end
        d = {$urandom, $urandom, $urandom};
        res_valid_in = push;
        res_nonce_in = d[95:64];
        res_hash_in  = d[63:0];
        res_pop      = pop;
        do_pop  = pop && (res_q.size() != 0);
        do_push = push && ((res_q.size() < RD) || do_pop);
        if (push && !do_push) ovf_m = 1'b1;
        if (do_pop) void'(res_q.pop_front());
        if (do_push) res_q.push_back(d);
        @(negedge clk);
        res_valid_in = 1'b0;
        res_pop      = 1'b0;
    endtask

    // Runs a whole job as the scanner would; abort_chunk < 0 means no abort.
    task automatic run_job(input logic [31:0] base, input logic [31:0] cnt,
                           input int abort_chunk, input int rdy_pct);
        longint      nch;
        int          word;
        int          cyc;
        logic [63:0] exp_d;
        logic [63:0] held_d;
        logic        held_l;
        bit          stalled;
        bit          rdy;
        nch = (longint'(cnt) + CH - 1) / CH;
        if (abort_chunk >= 0 && abort_chunk < nch) nch = abort_chunk + 1;
        start       = 1'b1;
        nonce_base  = base;
        nonce_count = cnt;
        ovf_m       = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (nch == 0) begin
            check("zero_job_done",  64'(job_done),  64'd1);
            check("zero_busy",      64'(busy),      64'd0);
            check("zero_req_valid", 64'(req_valid), 64'd0);
            @(negedge clk);
            check("zero_job_done_end", 64'(job_done),  64'd0);
            check("zero_req_valid2",   64'(req_valid), 64'd0);
            return;
        end
        check("start_busy", 64'(busy), 64'd1);
        for (int c = 0; c < nch; c++) begin
            word    = 0;
            cyc     = 0;
            stalled = 1'b0;
            held_d  = '0;
            held_l  = 1'b0;
            while (word < BW) begin
                if (cyc++ >= 1000) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL req_timeout: chunk %0d stuck at word %0d", c, word);
                    break;
                end
                check("req_valid", 64'(req_valid), 64'd1);
                if (stalled) begin
                    check("stall_data", req_data,      held_d);
                    check("stall_last", 64'(req_last), 64'(held_l));
                end
                abort     = (c == abort_chunk) && (word == 5);
                rdy       = ($urandom_range(99) < rdy_pct);
                req_ready = rdy;
                if (rdy && req_valid) begin
                    exp_d = (word == NIDX) ? {tpl_m[word][63:32], base + 32'(c * CH)} : tpl_m[word];
                    check("req_data", req_data,      exp_d);
                    check("req_last", 64'(req_last), 64'(word == BW - 1));
                    word++;
                    stalled = 1'b0;
                end else begin
                    stalled = req_valid;
                    held_d  = req_data;
                    held_l  = req_last;
                end
                @(negedge clk);
            end
            req_ready = 1'b0;
            abort     = 1'b0;
            check("wait_req_valid", 64'(req_valid), 64'd0);
            check("wait_busy",      64'(busy),      64'd1);
            repeat ($urandom_range(3)) begin
                @(negedge clk);
                check("wait_idle_valid", 64'(req_valid), 64'd0);
            end
            chunk_done = 1'b1;
            @(negedge clk);
            chunk_done = 1'b0;
            if (c < nch - 1) begin
                check("next_req_valid", 64'(req_valid), 64'd1);
                check("mid_job_done",   64'(job_done),  64'd0);
            end else begin
                check("job_done",       64'(job_done),  64'd1);
                check("done_busy",      64'(busy),      64'd0);
                check("done_req_valid", 64'(req_valid), 64'd0);
                @(negedge clk);
                check("job_done_end",   64'(job_done),  64'd0);
                check("idle_busy",      64'(busy),      64'd0);
                check("idle_req_valid", 64'(req_valid), 64'd0);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        tpl_wr       = 1'b0;
        tpl_addr     = '0;
        tpl_data     = '0;
        start        = 1'b0;
        nonce_base   = '0;
        nonce_count  = '0;
        abort        = 1'b0;
        req_ready    = 1'b0;
        chunk_done   = 1'b0;
        res_valid_in = 1'b0;
        res_nonce_in = '0;
        res_hash_in  = '0;
        res_pop      = 1'b0;
        ovf_m        = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        load_tpl(1'b1);
        run_job(32'h0000_0100, 32'd512, -1, 100);
        run_job(32'h0000_0100, 32'd512, -1, 50);
        run_job(32'h1234_5678, 32'd0,   -1, 50);
        run_job(32'hFFFF_FF80, 32'd300, -1, 50);
        run_job(32'h0000_2000, 32'd1024, 0, 50);

        load_tpl(1'b0);
        for (int j = 0; j < 2; j++) run_job($urandom, 32'($urandom_range(700, 1)), -1, 60);

        // Overflow: five pushes into a four-entry FIFO, then drain.
        for (int i = 0; i < 5; i++) fifo_cycle(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) fifo_cycle(1'b0, 1'b1);
        fifo_cycle(1'b0, 1'b0);
        run_job(32'h0, 32'd0, -1, 50);
        fifo_cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) fifo_cycle(1'b1, 1'b0);
        fifo_cycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) fifo_cycle(1'b0, 1'b1);
        for (int i = 0; i < 60; i++) fifo_cycle(1'($urandom_range(1)), 1'($urandom_range(1)));
        while (res_q.size() != 0) fifo_cycle(1'b0, 1'b1);
        fifo_cycle(1'b0, 1'b0);

        // Reset dropped asynchronously while waiting for chunk_done.
        run_job(32'h0, 32'd0, -1, 50);
        start       = 1'b1;
        nonce_base  = 32'h0000_5000;
        nonce_count = 32'd512;
        @(negedge clk);
        start     = 1'b0;
        req_ready = 1'b1;
        repeat (BW) @(negedge clk);
        req_ready = 1'b0;
        check("rst_wait_valid", 64'(req_valid), 64'd0);
        check("rst_wait_busy",  64'(busy),      64'd1);
        for (int i = 0; i < 5; i++) fifo_cycle(1'b1, 1'b0);
        check("rst_pre_ovf", 64'(res_overflow), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        res_q.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");
        run_job(32'h0000_0200, 32'd257, -1, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha3_scan_dispatcher.md
Name: sha3_scan_dispatcher

Overview:
- Initiator end of the scan request/result protocol: feeds a SHA3 scanner with work chunks and collects what it reports.
- Holds a block template loaded word-serially by the host, then walks a nonce range in CHUNK-sized steps.
- For each step it streams one request (the template with the current nonce patched in) and waits for the scanner's chunk-done before the next.
- Returned results are buffered in a small FIFO for the host. Sits between host/CSR logic and the scanner.

Parameters:
- BLOCK_WORDS, 24, 64-bit words per request.
- NONCE_IDX, 19, word index whose low 32 bits carry the nonce.
- CHUNK, 256, nonces covered by one request; power of two.
- RES_DEPTH, 4, result FIFO depth; power of two.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- tpl_wr  in  1  template word write strobe.
- tpl_addr  in  5  template word index, 0..BLOCK_WORDS-1.
- tpl_data  in  64  template word.
- start  in  1  start-job pulse; ignored unless idle.
- nonce_base  in  32  first nonce, sampled on start.
- nonce_count  in  32  number of nonces, sampled on start; 0 = no work.
- abort  in  1  stop issuing new chunks.
- busy  out  1  job in progress.
- job_done  out  1  one-cycle pulse at job end.
- req_valid  out  1  request word valid.
- req_data  out  64  request word.
- req_last  out  1  last word of request.
- req_ready  in  1  scanner accepts word.
- chunk_done  in  1  one-cycle pulse, scanner finished current request.
- res_valid_in  in  1  scanner result valid (no backpressure).
- res_nonce_in  in  32  winning nonce.
- res_hash_in  in  64  most-significant hash word.
- res_valid  out  1  FIFO non-empty.
- res_nonce  out  32  FIFO head nonce.
- res_hash  out  64  FIFO head hash word.
- res_pop  in  1  pop FIFO head.
- res_overflow  out  1  sticky; result dropped while FIFO full.

Behaviour:
- Reset values: all outputs 0; FSM IDLE; FIFO empty; template RAM not cleared (contents undefined).
- Template writes are accepted in any state but are only legal while idle. A write to tpl_addr >= BLOCK_WORDS is ignored.
- FSM states:
  - IDLE: on start && nonce_count!=0, latch cur=nonce_base and rem=nonce_count, then go to SEND with busy=1. On start && nonce_count==0, pulse job_done next cycle and stay IDLE.
  - SEND: word counter w=0..BLOCK_WORDS-1.
    - req_valid=1; req_data=template[w], except word NONCE_IDX = {template[w][63:32], cur}.
    - req_last=(w==BLOCK_WORDS-1).
    - Word advances only when req_valid&&req_ready. req_data and req_last are held stable while stalled.
    - After the last handshake, go to WAIT.
  - WAIT: on chunk_done: cur+=CHUNK (wraps mod 2^32); rem = (rem<=CHUNK) ? 0 : rem-CHUNK. If rem==0 or abort_pend, go to DONE; else go to SEND with w=0.
  - DONE: one cycle; job_done=1, busy=0, clear abort_pend, go to IDLE.
- abort: sets abort_pend in any non-IDLE state. A request in SEND is completed, never truncated. The job ends at the next chunk_done.
- Latency: start to first req_valid is 1 cycle. chunk_done to next req_valid is 1 cycle. Request-to-request spacing is bounded by the scanner only.
- The last chunk may cover more nonces than remain; the scanner over-scans and the host filters.
- Result FIFO (RES_DEPTH):
  - Push on res_valid_in. Pop on res_pop&&res_valid.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push while full with no pop: drop the result and set res_overflow.
  - res_overflow clears only on start (accepted) or reset.
  - res_pop while empty is ignored.
- Results are accepted in every state, including IDLE (stragglers).
- rst_n assertion mid-operation: immediate return to IDLE, outputs as reset.
- Pointer width is log2(RES_DEPTH)+1 to distinguish full from empty.

Decomposition:
- sha3_scan_pkg holds:
  - constants SCAN_WORD_W=64 and SCAN_NONCE_W=32;
  - typedef scan_result_t {nonce, hash_msw};
  - enum dispatch_state_e {IDLE,SEND,WAIT,DONE}.
- One sub-module, sha3_result_fifo: a synchronous FIFO of scan_result_t with an overflow flag, reusable by other initiators.

Test Plan:
- Load template words i = 64'h1111_0000_0000_0000+i; base=32'h100, count=512, CHUNK=256 -> two requests of 24 words each. Word 19 = 64'h1111_0000_0000_0100, then 64'h1111_0000_0000_0200. One job_done after the 2nd chunk_done.
- Toggle req_ready randomly at 50% -> every word is delivered exactly once, in order; req_data/req_last are stable during stalls.
- Set count=0 -> no req_valid; job_done pulses 1 cycle after start; busy stays 0.
- base=32'hFFFF_FF80, count=300 -> nonces FFFF_FF80, then 0000_0080 (wrap); 2 chunks.
- Push 5 results with no pops (RES_DEPTH=4) -> res_overflow=1 and the first 4 are popped intact. Push and pop in the same cycle while full -> no overflow.
- Assert abort mid-SEND of chunk 1 of 4 -> chunk 1 completes, no chunk 2, job_done after chunk 1's chunk_done. Separately, drop rst_n mid-WAIT -> all outputs 0 asynchronously.
